// File: rtl/msdap_pkg.sv
// Shared types and default sizing for the MSDAP serial frame transmitter.
package msdap_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned DEF_WORD_W     = 16;
    localparam int unsigned DEF_CHANNELS   = 2;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_CNT_W      = 16;

endpackage

// File: rtl/msdap_sync_fifo.sv
// Synchronous FIFO with registered level/full/empty; a pushed entry is visible one cycle later.
module msdap_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LVL_W = AW + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
        else if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign level_o    = level_q;

endmodule

// File: rtl/msdap_serial_frame_tx.sv
// Multi-lane bit-serial frame transmitter for the MSDAP input port: FIFO-buffered words,
// one bit per step (bitEn && inReady), frame on each word's first bit.
module msdap_serial_frame_tx
    import msdap_pkg::*;
#(
    parameter int unsigned WORD_W     = DEF_WORD_W,
    parameter int unsigned CHANNELS   = DEF_CHANNELS,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter bit          LSB_FIRST  = 1'b0,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    localparam int unsigned DATA_W = CHANNELS * WORD_W,
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                sClk,
    input  logic                reset,
    input  logic                bitEn,
    input  logic                inReady,
    input  logic                wrValid,
    input  logic [DATA_W-1:0]   wrData,
    output logic                wrReady,
    output logic                frame,
    output logic [CHANNELS-1:0] serOut,
    output logic                busy,
    output logic [LVL_W-1:0]    fifoLevel,
    output logic [CNT_W-1:0]    wordsSent,
    output logic                overflow
);

    localparam int unsigned IDX_W = $clog2(WORD_W);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                frame_q, frame_d;
    logic [CHANNELS-1:0] ser_q, ser_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    sent_q, sent_d;
    logic                ovf_q, ovf_d;
    logic                pop;
    logic                step;
    logic [DATA_W-1:0]   fifo_data;
    logic                fifo_full;
    logic                fifo_empty;

    // bitIdx counts down; LSB-first mirrors it onto the lane bit position.
    function automatic logic [CHANNELS-1:0] pick_bits(input logic [DATA_W-1:0] w,
                                                      input logic [IDX_W-1:0]  idx);
        logic [CHANNELS-1:0] bits;
        logic [IDX_W-1:0]    pos;
        logic [WORD_W-1:0]   lane;
        bits = '0;
        pos  = LSB_FIRST ? (IDX_W'(WORD_W - 1) - idx) : idx;
        for (int k = 0; k < CHANNELS; k++) begin
            lane    = w[k*WORD_W +: WORD_W];
            bits[k] = lane[pos];
        end
        return bits;
    endfunction

    assign step = bitEn & inReady;

    msdap_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (sClk),
        .reset_i     (reset),
        .push_i      (wrValid),
        .push_data_i (wrData),
        .pop_i       (pop),
        .pop_data_o  (fifo_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifoLevel)
    );

    always_ff @(posedge sClk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (step && !fifo_empty) state_d = SHIFT;
            SHIFT:   if (step && idx_q == '0 && fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath update; a step with bitIdx==0 in SHIFT is the completion step.
    always_comb begin
        idx_d   = idx_q;
        word_d  = word_q;
        frame_d = frame_q;
        ser_d   = ser_q;
        busy_d  = busy_q;
        sent_d  = sent_q;
        pop     = 1'b0;
        ovf_d   = ovf_q | (wrValid & fifo_full);
        if (step) begin
            frame_d = 1'b0;
            if (state_q == SHIFT && idx_q != '0) begin
                idx_d = idx_q - IDX_W'(1);
                ser_d = pick_bits(word_q, idx_q - IDX_W'(1));
            end else begin
                if (state_q == SHIFT) sent_d = sent_q + CNT_W'(1);
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    word_d  = fifo_data;
                    idx_d   = IDX_W'(WORD_W - 1);
                    ser_d   = pick_bits(fifo_data, IDX_W'(WORD_W - 1));
                    frame_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    ser_d  = '0;
                    busy_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge sClk) begin
        if (reset) begin
            idx_q   <= '0;
            word_q  <= '0;
            frame_q <= 1'b0;
            ser_q   <= '0;
            busy_q  <= 1'b0;
            sent_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            word_q  <= word_d;
            frame_q <= frame_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            sent_q  <= sent_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wrReady   = ~fifo_full;
    assign frame     = frame_q;
    assign serOut    = ser_q;
    assign busy      = busy_q;
    assign wordsSent = sent_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_msdap_serial_frame_tx.sv
// Bench for msdap_serial_frame_tx: default 2x16 MSB-first instance plus a 4x24 LSB-first instance.
module tb_msdap_serial_frame_tx;

    localparam int unsigned W  = 16;
    localparam int unsigned W6 = 24;
    localparam int unsigned C6 = 4;

    logic        clk = 1'b0;
    logic        reset, bit_en, in_ready;
    logic        wr_valid, wr_ready, frame, busy, overflow;
    logic [31:0] wr_data;
    logic [1:0]  ser_out;
    logic [2:0]  fifo_level;
    logic [15:0] words_sent;

    logic        wr_valid6, wr_ready6, frame6, busy6, overflow6;
    logic [95:0] wr_data6;
    logic [3:0]  ser6;
    logic [2:0]  level6;
    logic [3:0]  sent6;

    int errors = 0;
    int checks = 0;
    logic [31:0] words[$];
    logic [95:0] words6[17];

    always #5 clk = ~clk;

    msdap_serial_frame_tx dut (
        .sClk(clk), .reset(reset), .bitEn(bit_en), .inReady(in_ready),
        .wrValid(wr_valid), .wrData(wr_data), .wrReady(wr_ready), .frame(frame),
        .serOut(ser_out), .busy(busy), .fifoLevel(fifo_level), .wordsSent(words_sent),
        .overflow(overflow)
    );

    msdap_serial_frame_tx #(.WORD_W(24), .CHANNELS(4), .FIFO_DEPTH(4), .LSB_FIRST(1'b1), .CNT_W(4)) dut6 (
        .sClk(clk), .reset(reset), .bitEn(bit_en), .inReady(in_ready),
        .wrValid(wr_valid6), .wrData(wr_data6), .wrReady(wr_ready6), .frame(frame6),
        .serOut(ser6), .busy(busy6), .fifoLevel(level6), .wordsSent(sent6),
        .overflow(overflow6)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [22:0] obs();
        return {frame, ser_out, busy, fifo_level, words_sent};
    endfunction

    // Expected status after the j-th step, with n words queued up front and no later pushes.
    function automatic logic [22:0] exp_status(input int j, input int n);
        logic        fr, bz;
        logic [1:0]  s;
        logic [2:0]  lv;
        logic [31:0] t;
        if (j < n * W) begin
            t  = words[j / W] >> (W - 1 - (j % W));
            s  = {t[W], t[0]};
            fr = ((j % W) == 0);
            bz = 1'b1;
            lv = 3'(n - (j / W + 1));
        end else begin
            s  = '0;
            fr = 1'b0;
            bz = 1'b0;
            lv = '0;
        end
        return {fr, s, bz, lv, 16'(j / W)};
    endfunction

    task automatic slot(input logic rdy);
        @(negedge clk); bit_en = 1'b1; in_ready = rdy;
        @(negedge clk); bit_en = 1'b0; in_ready = 1'b1;
    endtask

    task automatic push(input logic [31:0] d);
        @(negedge clk); wr_valid = 1'b1; wr_data = d;
        @(negedge clk); wr_valid = 1'b0;
        words.push_back(d);
    endtask

    task automatic push6(input logic [95:0] d);
        @(negedge clk); wr_valid6 = 1'b1; wr_data6 = d;
        @(negedge clk); wr_valid6 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; bit_en = 1'b0; in_ready = 1'b1; wr_valid = 1'b0; wr_valid6 = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
        words.delete();
    endtask

    // Runs steps start_j..end_j, optionally inserting stall strobes, checking each slot and the hold gap.
    task automatic stream_check(input int start_j, input int end_j, input int stall_at,
                                input int stall_n, input int stall_pct);
        int n = words.size();
        int j = start_j;
        int stalls = 0;
        logic [22:0] prev, cur, exp;
        prev = (start_j == 0) ? obs() : exp_status(start_j - 1, n);
        while (j <= end_j) begin
            if ((j == stall_at && stalls < stall_n) || ($urandom_range(0, 99) < stall_pct)) begin
                stalls++;
                slot(1'b0);
                cur = obs();
                checks++;
                if (cur !== prev) begin
                    errors++;
                    $display("FAIL stall_freeze j=%0d got=%h expected=%h", j, cur, prev);
                end
            end else begin
                slot(1'b1);
                cur = obs();
                exp = exp_status(j, n);
                checks++;
                if (cur !== exp) begin
                    errors++;
                    $display("FAIL step j=%0d got=%h expected=%h", j, cur, exp);
                end
                prev = exp;
                j++;
            end
            @(negedge clk); @(negedge clk);
            cur = obs();
            checks++;
            if (cur !== prev) begin
                errors++;
                $display("FAIL hold_between_strobes j=%0d got=%h expected=%h", j, cur, prev);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs() !== 23'(0)) begin
            errors++; $display("FAIL reset_outputs got=%h expected=0", obs());
        end
        checks++;
        if ({wr_ready, overflow} !== 2'b10) begin
            errors++; $display("FAIL reset_flags got=%b expected=10", {wr_ready, overflow});
        end
        checks++;
        if ({frame6, ser6, busy6, level6, sent6, overflow6, wr_ready6} !== 15'b1) begin
            errors++; $display("FAIL reset_wide got=%h expected=1",
                               {frame6, ser6, busy6, level6, sent6, overflow6, wr_ready6});
        end
    endtask

    task automatic test_single_word();
        logic [22:0] exp;
        do_reset();
        // Push and strobe in the same cycle: the entry is not yet visible.
        @(negedge clk); wr_valid = 1'b1; wr_data = {16'hA5C3, 16'h1234}; bit_en = 1'b1; in_ready = 1'b1;
        @(negedge clk); wr_valid = 1'b0; bit_en = 1'b0;
        words.push_back({16'hA5C3, 16'h1234});
        exp = {1'b0, 2'b00, 1'b0, 3'd1, 16'd0};
        checks++;
        if (obs() !== exp) begin
            errors++; $display("FAIL no_bypass got=%h expected=%h", obs(), exp);
        end
        @(negedge clk);
        stream_check(0, W, -1, 0, 0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) push($urandom());
        checks++;
        if (fifo_level !== 3'd3) begin
            errors++; $display("FAIL b2b_level got=%0d expected=3", fifo_level);
        end
        stream_check(0, 3 * W, -1, 0, 0);
    endtask

    task automatic test_stall();
        do_reset();
        push($urandom());
        stream_check(0, W, 10, 5, 0);
        do_reset();
        for (int i = 0; i < 3; i++) push($urandom());
        stream_check(0, 3 * W, -1, 0, 30);
    endtask

    task automatic test_push_pop_same_cycle();
        logic [31:0] d;
        logic [22:0] exp;
        do_reset();
        push($urandom());
        push($urandom());
        d = $urandom();
        @(negedge clk); bit_en = 1'b1; in_ready = 1'b1; wr_valid = 1'b1; wr_data = d;
        @(negedge clk); bit_en = 1'b0; wr_valid = 1'b0;
        words.push_back(d);
        exp = exp_status(0, 3);
        checks++;
        if (obs() !== exp) begin
            errors++; $display("FAIL push_pop_level got=%h expected=%h", obs(), exp);
        end
        stream_check(1, 3 * W, -1, 0, 20);
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        do_reset();
        @(negedge clk);
        wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                checks++;
                if (wr_ready !== 1'b0) begin
                    errors++; $display("FAIL full_wrready got=%b expected=0", wr_ready);
                end
            end
            d = $urandom();
            wr_data = d;
            if (i < 4) words.push_back(d);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        checks++;
        if ({overflow, fifo_level} !== {1'b1, 3'd4}) begin
            errors++; $display("FAIL overflow_set got=%b/%0d expected=1/4", overflow, fifo_level);
        end
        stream_check(0, 4 * W, -1, 0, 10);
        checks++;
        if ({overflow, wr_ready} !== 2'b11) begin
            errors++; $display("FAIL overflow_sticky got=%b expected=11", {overflow, wr_ready});
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        for (int i = 0; i < 3; i++) push($urandom());
        stream_check(0, 7, -1, 0, 0);
        @(negedge clk); reset = 1'b1; bit_en = 1'b1; in_ready = 1'b1;
        @(negedge clk); bit_en = 1'b0;
        checks++;
        if ({obs(), wr_ready} !== 24'b1) begin
            errors++; $display("FAIL reset_abort got=%h expected=1", {obs(), wr_ready});
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slot(1'b1);
            checks++;
            if (obs() !== 23'(0)) begin
                errors++; $display("FAIL after_reset_idle i=%0d got=%h expected=0", i, obs());
            end
        end
    endtask

    task automatic test_wide_lsb_first();
        logic [95:0] t;
        logic [3:0]  e;
        do_reset();
        for (int k = 0; k < 4; k++) words6[0][k*24 +: 24] = 24'h00000F << k;
        for (int m = 1; m < 17; m++) words6[m] = {$urandom(), $urandom(), $urandom()};
        push6(words6[0]);
        push6(words6[1]);
        for (int m = 0; m < 17; m++) begin
            for (int i = 0; i < int'(W6); i++) begin
                slot(1'b1);
                for (int k = 0; k < int'(C6); k++) begin
                    t = words6[m] >> (k * 24 + i);
                    e[k] = t[0];
                end
                checks++;
                if ({frame6, ser6} !== {(i == 0), e}) begin
                    errors++;
                    $display("FAIL wide_bit m=%0d i=%0d got=%b expected=%b", m, i, {frame6, ser6}, {(i == 0), e});
                end
                if (i == 0) begin
                    checks++;
                    if ({busy6, sent6} !== {1'b1, 4'(m)}) begin
                        errors++;
                        $display("FAIL wide_count m=%0d got=%b/%0d expected=1/%0d", m, busy6, sent6, m % 16);
                    end
                    if (m + 2 < 17) push6(words6[m + 2]);
                end
            end
        end
        slot(1'b1);
        checks++;
        if ({frame6, ser6, busy6, level6, sent6} !== {1'b0, 4'b0, 1'b0, 3'd0, 4'd1}) begin
            errors++;
            $display("FAIL wide_done got=%b expected=%b", {frame6, ser6, busy6, level6, sent6},
                     {1'b0, 4'b0, 1'b0, 3'd0, 4'd1});
        end
    endtask

    initial begin
        reset = 1'b1; bit_en = 1'b0; in_ready = 1'b1;
        wr_valid = 1'b0; wr_data = '0; wr_valid6 = 1'b0; wr_data6 = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_push_pop_same_cycle();
        test_overflow();
        test_reset_mid_word();
        test_wide_lsb_first();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
